// File: rtl/matrix_pkg.sv
// Shared constants for the matrix-multiplication datapath: memory map, loader FSM
// encoding, ASCII characters recognised by the loader, and the SRAM layout helper.
package matrix_pkg;

   localparam int unsigned M_SIZE = 4;
   localparam int unsigned A_BASE = 0;
   localparam int unsigned B_BASE = M_SIZE * M_SIZE;
   localparam int unsigned C_BASE = 2 * M_SIZE * M_SIZE;

   typedef logic [2:0] loader_state_t;
   localparam loader_state_t StIdle  = 3'd0;
   localparam loader_state_t StSkip  = 3'd1;
   localparam loader_state_t StDigit = 3'd2;
   localparam loader_state_t StWrite = 3'd3;
   localparam loader_state_t StDone  = 3'd4;
   localparam loader_state_t StError = 3'd5;

   localparam logic [7:0] CH_CR    = 8'h0d;
   localparam logic [7:0] CH_LF    = 8'h0a;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_COMMA = 8'h2c;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_UA    = 8'h41;
   localparam logic [7:0] CH_UF    = 8'h46;
   localparam logic [7:0] CH_LA    = 8'h61;
   localparam logic [7:0] CH_LF_HEX = 8'h66;

   // Text arrives row-major; the multiplier reads column-major, two matrices back to back.
   function automatic int unsigned elem_addr(input int unsigned e, input int unsigned m);
      int unsigned sq;
      sq = m * m;
      return (e / sq) * sq + (e / m) % m + (e % m) * m;
   endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII classifier: flags hex digits and separators and yields the
// nibble value of a hex digit.
module hex_ascii_decode (
   input  logic [7:0] ascii,
   output logic       is_hex,
   output logic       is_sep,
   output logic [3:0] nibble
);
   import matrix_pkg::*;

   always_comb begin
      is_hex = 1'b0;
      is_sep = 1'b0;
      nibble = 4'h0;
      if (ascii >= CH_0 && ascii <= CH_9) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - CH_0);
      end else if (ascii >= CH_UA && ascii <= CH_UF) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - CH_UA + 8'd10);
      end else if (ascii >= CH_LA && ascii <= CH_LF_HEX) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - CH_LA + 8'd10);
      end else if (ascii == CH_SP || ascii == CH_TAB || ascii == CH_COMMA ||
                   ascii == CH_CR || ascii == CH_LF) begin
         is_sep = 1'b1;
      end
   end

endmodule

// File: rtl/uart_matrix_loader.sv
// Parses hex tokens from the UART byte stream and writes matrices A then B into
// the shared SRAM in column-major order; raises done once every element is stored.
module uart_matrix_loader #(
   parameter int unsigned M_SIZE     = 4,
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned MAX_DIGITS = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic                                      received,
   input  logic [7:0]                                rx_byte,
   input  logic                                      recv_error,
   output logic                                      sram_we,
   output logic [ADDR_WIDTH-1:0]                     sram_addr,
   output logic [DATA_WIDTH-1:0]                     sram_data,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      error,
   output logic [$clog2(2*M_SIZE*M_SIZE+1)-1:0]      elem_count
);
   import matrix_pkg::*;

   localparam int unsigned NumElems   = 2 * M_SIZE * M_SIZE;
   localparam int unsigned CountWidth = $clog2(NumElems + 1);
   localparam int unsigned AccWidth   = 4 * MAX_DIGITS;
   localparam int unsigned DigWidth   = $clog2(MAX_DIGITS + 1);

   loader_state_t                 state_q, state_d;
   logic [AccWidth-1:0]           acc_q, acc_d;
   logic [DigWidth-1:0]           dcnt_q, dcnt_d;
   logic [CountWidth-1:0]         count_q, count_d;
   logic                          we_q, we_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0]         data_q, data_d;

   logic       is_hex;
   logic       is_sep;
   logic [3:0] nibble;

   hex_ascii_decode u_decode (
      .ascii  (rx_byte),
      .is_hex (is_hex),
      .is_sep (is_sep),
      .nibble (nibble)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dcnt_d  = dcnt_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (start) begin
         // Restart drops any token in flight and any byte arriving alongside.
         state_d = StSkip;
         acc_d   = '0;
         dcnt_d  = '0;
         count_d = '0;
      end else begin
         case (state_q)
            StSkip: begin
               if (recv_error) begin
                  state_d = StError;
               end else if (received) begin
                  if (is_hex) begin
                     acc_d   = AccWidth'(nibble);
                     dcnt_d  = DigWidth'(1);
                     state_d = StDigit;
                  end else if (!is_sep) begin
                     state_d = StError;
                  end
               end
            end
            StDigit: begin
               if (recv_error) begin
                  state_d = StError;
               end else if (received) begin
                  if (is_hex) begin
                     if (dcnt_q < DigWidth'(MAX_DIGITS)) begin
                        acc_d  = {acc_q[AccWidth-5:0], nibble};
                        dcnt_d = dcnt_q + DigWidth'(1);
                     end else begin
                        state_d = StError;
                     end
                  end else if (is_sep) begin
                     state_d = StWrite;
                     we_d    = 1'b1;
                     addr_d  = ADDR_WIDTH'(elem_addr(32'(count_q), M_SIZE));
                     data_d  = DATA_WIDTH'(acc_q);
                  end else begin
                     state_d = StError;
                  end
               end
            end
            StWrite: begin
               if (recv_error) begin
                  state_d = StError;
               end else begin
                  count_d = count_q + CountWidth'(1);
                  state_d = (count_q == CountWidth'(NumElems - 1)) ? StDone : StSkip;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         dcnt_q  <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dcnt_q  <= dcnt_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign sram_we    = we_q;
   assign sram_addr  = addr_q;
   assign sram_data  = data_q;
   assign busy       = (state_q == StSkip) || (state_q == StDigit) || (state_q == StWrite);
   assign done       = (state_q == StDone);
   assign error      = (state_q == StError);
   assign elem_count = count_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Directed bench for uart_matrix_loader: expected SRAM writes are queued as tokens
// are sent and compared by a write monitor; status outputs are checked inline.
module tb_uart_matrix_loader;

   localparam int unsigned CW = $clog2(2 * 4 * 4 + 1);

   typedef struct packed {
      logic [10:0] addr;
      logic [17:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          received = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          recv_error = 1'b0;
   logic          sram_we;
   logic [10:0]   sram_addr;
   logic [17:0]   sram_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [CW-1:0] elem_count;

   int checks = 0;
   int errors = 0;
   wr_t exp_q[$];
   logic [17:0] mem [0:63];

   uart_matrix_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .received   (received),
      .rx_byte    (rx_byte),
      .recv_error (recv_error),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_data  (sram_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .elem_count (elem_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {sram_addr, sram_data[17:0]}, 32'hffffffff);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(sram_addr), 32'(e.addr));
            chk("wr_data", 32'(sram_data), 32'(e.data));
            if (sram_addr < 11'd64) mem[sram_addr[5:0]] = sram_data;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      received = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      received = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         idle(2);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [7:0] hex_char(input int v);
      return (v < 10) ? 8'(8'h30 + v) : 8'(8'h41 + v - 10);
   endfunction

   function automatic logic [10:0] ref_addr(input int e);
      return 11'((e / 16) * 16 + (e / 4) % 4 + (e % 4) * 4);
   endfunction

   task automatic expect_wr(input logic [10:0] a, input logic [17:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      idle(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_we", 32'(sram_we), 0);
      chk("rst_count", 32'(elem_count), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      rst = 1'b0;
      send_str("12 ");
      chk("idle_ignores", 32'(busy), 0);

      // Full load of 32 tokens 0x01..0x20
      pulse_start();
      chk("start_busy", 32'(busy), 1);
      for (int i = 1; i <= 32; i++) begin
         expect_wr(ref_addr(i - 1), 18'(i));
         send_byte(hex_char(i / 16));
         idle(2);
         send_byte(hex_char(i % 16));
         idle(2);
         if (i < 32) begin
            send_str(" ");
         end else begin
            send_byte(8'h0d);
            chk("done_not_yet", 32'(done), 0);
            idle(1);
            chk("done_rise", 32'(done), 1);
            chk("full_count", 32'(elem_count), 32);
            send_str("\n");
         end
      end
      chk("full_done", 32'(done), 1);
      chk("full_error", 32'(error), 0);
      chk("full_busy", 32'(busy), 0);
      chk("mem4", 32'(mem[4]), 32'h02);
      chk("mem1", 32'(mem[1]), 32'h05);
      chk("mem16", 32'(mem[16]), 32'h11);
      chk("full_drained", exp_q.size(), 0);

      // Mixed separators and case
      pulse_start();
      chk("restart_count", 32'(elem_count), 0);
      chk("restart_done", 32'(done), 0);
      expect_wr(11'd0, 18'h0ff);
      expect_wr(11'd4, 18'h00a);
      expect_wr(11'd8, 18'h00b);
      send_str("ff,\tA\r\n0b ");
      chk("mixed_busy", 32'(busy), 1);
      chk("mixed_count", 32'(elem_count), 3);

      // Digit overflow
      pulse_start();
      send_str("12");
      chk("ovf_pre", 32'(error), 0);
      send_byte("3");
      chk("ovf_error", 32'(error), 1);
      send_str(" ");
      chk("ovf_busy", 32'(busy), 0);
      pulse_start();
      chk("ovf_clear", 32'(error), 0);
      chk("ovf_count", 32'(elem_count), 0);

      // Invalid character, then framing error mid-token
      send_str("1");
      send_byte("G");
      chk("badchar_error", 32'(error), 1);
      send_str(" ");
      pulse_start();
      send_str("5");
      @(negedge clk);
      recv_error = 1'b1;
      @(negedge clk);
      recv_error = 1'b0;
      chk("recverr_error", 32'(error), 1);
      send_str(" ");

      // Restart mid-token with a simultaneous byte
      pulse_start();
      send_str("7");
      @(negedge clk);
      start    = 1'b1;
      received = 1'b1;
      rx_byte  = "8";
      @(negedge clk);
      start    = 1'b0;
      received = 1'b0;
      idle(2);
      expect_wr(11'd0, 18'h009);
      send_str("9 ");
      chk("restart_tok_count", 32'(elem_count), 1);

      // Reset mid-load
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         expect_wr(ref_addr(i), 18'(8'h30 + i));
         send_byte("3");
         idle(2);
         send_byte(hex_char(i));
         idle(2);
         send_str(" ");
      end
      chk("pre_rst_count", 32'(elem_count), 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_count", 32'(elem_count), 0);
      chk("mrst_addr", 32'(sram_addr), 0);
      chk("mrst_data", 32'(sram_data), 0);
      send_str("ab ");
      chk("mrst_ignore_count", 32'(elem_count), 0);
      chk("mrst_ignore_error", 32'(error), 0);

      idle(4);
      chk("pending_writes", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
